vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
Generates 640x480@60 Hz VGA timing from the 100 MHz system clock. Outputs the current pixel coordinate (x, y), hsync/vsync, a visible-area flag, and per-frame strobes. It is the timing source for the pixel renderer and the game-state update logic. x/y feed the renderer directly; hsync/vsync go to the board pins.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >= 2
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch, in pixels
H_SYNC, 96, horizontal sync width, in pixels
H_BACK, 48, horizontal back porch, in pixels
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch, in lines
V_SYNC, 2, vertical sync width, in lines
V_BACK, 33, vertical back porch, in lines
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
pixel_tick  out  1  one-clk pulse, once every CLK_DIV clks; marks a pixel advance
x  out  10  current horizontal count, 0..H_TOTAL-1
y  out  10  current vertical count, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity set by SYNC_POL
vsync  out  1  vertical sync, polarity set by SYNC_POL
video_on  out  1  high when x < H_DISPLAY and y < V_DISPLAY
frame_start  out  1  one-clk pulse when the counters enter (0,0)
vblank_start  out  1  one-clk pulse when the counters enter (0,V_DISPLAY); game logic updates on this strobe

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_* values (800); V_TOTAL = sum of the four V_* values (525).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - pixel_tick = 1 in exactly the clk where div_cnt == CLK_DIV-1; it is combinational from div_cnt.
- Counters advance only on a clk edge where pixel_tick = 1:
  - if x == H_TOTAL-1: x <= 0; y <= (y == V_TOTAL-1) ? 0 : y+1
  - otherwise: x <= x+1
- Register alignment:
  - hsync, vsync, video_on, frame_start and vblank_start are registered.
  - They are computed from the next-state counter values, so all of them change on the same edge as x/y.
  - No pipeline skew between the coordinate and its flags is permitted.
- Sync windows:
  - hsync active iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync active iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC, i.e. 490..491.
  - Outside these windows the pin sits at the inactive level, ~SYNC_POL.
- Strobes:
  - frame_start and vblank_start are high for exactly one clk, on the edge where the counters take the stated value.
  - They are never asserted for more than one clk per frame.
- Reset (synchronous, active-high):
  - div_cnt=0, x=0, y=0.
  - hsync=vsync=~SYNC_POL; video_on=1, matching the (0,0) coordinate.
  - frame_start=0, vblank_start=0.
- After reset deasserts:
  - The first pixel_tick occurs CLK_DIV clks later.
  - The first frame_start occurs only at the next wrap to (0,0); exiting reset does not emit one.
- Reset mid-frame: takes effect on the next edge regardless of pixel_tick. Any partial sync pulse is truncated, with no glitch beyond the truncation.
- Cadence: line period = H_TOTAL*CLK_DIV = 3200 clks; frame period = V_TOTAL*3200 = 1,680,000 clks.
- Width rule: all counter compares are 10-bit unsigned. H_TOTAL-1 = 799 and V_TOTAL-1 = 524 both fit, so no overflow path exists.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL);
  - SYNC_POL;
  - the coordinate width COORD_W = 10 (also used by the renderer and game logic).
- One sub-module: vga_pixel_tick. It holds the CLK_DIV divider and emits pixel_tick; it is reusable by any logic that must run at the pixel rate.
- h/v counters and the sync/flag registers stay in vga_sync_gen.

Test Plan:
- Reset held 5 clks then released -> x=0, y=0, hsync=vsync=1, video_on=1, no strobes; first pixel_tick on clk 4 after release; x=1 one clk later.
- Run one line -> x reaches 799 then wraps to 0 with y=1. hsync low for exactly 96*4=384 clks, starting when x becomes 656. video_on falls when x becomes 640.
- Run a full frame -> vsync low exactly while y=490..491 (2*3200 = 6400 clks). vblank_start pulses once at (0,480). frame_start pulses once at (0,0), 1,680,000 clks after the previous frame_start.
- Count video_on-high pixel_ticks over one frame -> exactly 640*480 = 307,200.
- Assert reset at x=700, y=490 (mid hsync and vsync) -> next edge x=0, y=0, both sync pins inactive, no frame_start pulse.
- Alignment check on every clk -> video_on == (x<640 && y<480), hsync == !(656<=x<752), vsync == !(490<=y<492); pixel_tick period is always 4.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the sync generator, renderer and game logic.
package vga_pkg;

  // Coordinate width used everywhere a pixel position is carried
  localparam int COORD_W = 10;

  // Pixel-clock divider from the 100 MHz system clock
  localparam int CLK_DIV = 4;

  // 640x480@60 Hz horizontal timing, in pixels
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  // 640x480@60 Hz vertical timing, in lines
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Active level of hsync/vsync (0 = active-low)
  localparam logic SYNC_POL = 1'b0;

endpackage

// File: rtl/vga_pixel_tick.sv
// Divides the system clock down to a one-clk pixel-rate strobe.
module vga_pixel_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Free-running divider counting 0..CLK_DIV-1, restarting from 0 on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Strobe is decoded straight from the count so it lines up with the wrap
  always_comb begin
    pixel_tick = (div_cnt == DIV_LAST);
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel coordinates, sync pins, visible flag and
// per-frame strobes, all registered together so no flag lags its coordinate.
module vga_sync_gen #(
  parameter int   CLK_DIV   = vga_pkg::CLK_DIV,
  parameter int   H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int   H_FRONT   = vga_pkg::H_FRONT,
  parameter int   H_SYNC    = vga_pkg::H_SYNC,
  parameter int   H_BACK    = vga_pkg::H_BACK,
  parameter int   V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int   V_FRONT   = vga_pkg::V_FRONT,
  parameter int   V_SYNC    = vga_pkg::V_SYNC,
  parameter int   V_BACK    = vga_pkg::V_BACK,
  parameter logic SYNC_POL  = vga_pkg::SYNC_POL
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        pixel_tick,
  output logic [vga_pkg::COORD_W-1:0] x,
  output logic [vga_pkg::COORD_W-1:0] y,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        video_on,
  output logic                        frame_start,
  output logic                        vblank_start
);

  localparam int CW = vga_pkg::COORD_W;

  // Window edges pre-sized to the coordinate width so every compare is CW-bit unsigned
  localparam logic [CW-1:0] X_LAST   = CW'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CW-1:0] X_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] Y_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          video_on_nxt;
  logic          frame_start_nxt;
  logic          vblank_start_nxt;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick)
  );

  // Next coordinate and the flags decoded from it, so flags land on the same edge as x/y
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (pixel_tick) begin
      if (x == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x_nxt = x + 1'b1;
      end
    end
    video_on_nxt     = (x_nxt < X_VIS) && (y_nxt < Y_VIS);
    hsync_nxt        = ((x_nxt >= HS_BEGIN) && (x_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt        = ((y_nxt >= VS_BEGIN) && (y_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    frame_start_nxt  = pixel_tick && (x_nxt == '0) && (y_nxt == '0);
    vblank_start_nxt = pixel_tick && (x_nxt == '0) && (y_nxt == Y_VIS);
  end

  // Coordinate and flag registers; reset parks at (0,0) with sync idle and no strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      x            <= '0;
      y            <= '0;
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      video_on     <= 1'b1;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      x            <= x_nxt;
      y            <= y_nxt;
      hsync        <= hsync_nxt;
      vsync        <= vsync_nxt;
      video_on     <= video_on_nxt;
      frame_start  <= frame_start_nxt;
      vblank_start <= vblank_start_nxt;
    end
  end

endmodule
